// File: rtl/spi_mnrch_pkg.sv
// rtl/spi_mnrch_pkg.sv - shared types and timing constants for the SPI monarch
//
// Contents:
//   state_t   : IDLE, FRONT, SHIFT, BACK
//   front_ld  : divider preload for the 3/4-period front porch (23 for DIV_W=5)
//   smpl_pt   : divider value at which MISO is captured (half-1, lands on SCLK rise)
//   shft_pt   : divider value at which the shift register moves (all-ones, SCLK fall)
//   CMD_RD / CMD_RD_BIT : read flag value and its position in the command word
// Optional feature macro used by the bundle: SPI_MNRCH_XACT_CNT_EN

package spi_mnrch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } state_t;

    localparam int DIV_W_DEF  = 5;
    localparam int DATA_W_DEF = 16;

    // Preload so that the first SCLK fall comes 9 clk after SS_n drops.
    function automatic int front_ld(input int div_w);
        return ((3 * (1 << div_w)) / 4) - 1;
    endfunction

    function automatic int smpl_pt(input int div_w);
        return (1 << (div_w - 1)) - 1;
    endfunction

    function automatic int shft_pt(input int div_w);
        return (1 << div_w) - 1;
    endfunction

    localparam int FRONT_LD = front_ld(DIV_W_DEF);
    localparam int SMPL_PT  = smpl_pt(DIV_W_DEF);
    localparam int SHFT_PT  = shft_pt(DIV_W_DEF);

    localparam logic CMD_RD     = 1'b1;
    localparam int   CMD_RD_BIT = DATA_W_DEF - 1;

endpackage

// File: rtl/spi_mnrch_if.sv
// rtl/spi_mnrch_if.sv - command/response and SPI pin bundle for the SPI monarch
//
// Signals:
//   wrt      : 1-clk pulse, start a transaction with cmd
//   cmd      : DATA_W word sent MSB first
//   done     : transaction complete, held until the next accepted wrt
//   resp     : DATA_W word received on MISO, valid while done=1
//   SS_n     : serf select, active low
//   SCLK     : serial clock, mode 3 (idles high)
//   MOSI     : monarch out
//   MISO     : serf out
//   xact_cnt : completed-transaction count   (only with SPI_MNRCH_XACT_CNT_EN)
//   busy     : ~SS_n                          (only with SPI_MNRCH_XACT_CNT_EN)
// Modports: master (the monarch), slave (the side that issues commands and drives MISO).

interface spi_mnrch_if
    import spi_mnrch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              wrt;
    logic [DATA_W-1:0] cmd;
    logic              done;
    logic [DATA_W-1:0] resp;
    logic              SS_n;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;

`ifdef SPI_MNRCH_XACT_CNT_EN
    logic [15:0]       xact_cnt;
    logic              busy;

    modport master (
        input  wrt, cmd, MISO,
        output done, resp, SS_n, SCLK, MOSI, xact_cnt, busy
    );

    modport slave (
        output wrt, cmd, MISO,
        input  done, resp, SS_n, SCLK, MOSI, xact_cnt, busy
    );
`else
    modport master (
        input  wrt, cmd, MISO,
        output done, resp, SS_n, SCLK, MOSI
    );

    modport slave (
        output wrt, cmd, MISO,
        input  done, resp, SS_n, SCLK, MOSI
    );
`endif

endinterface

// File: rtl/spi_mnrch.sv
// rtl/spi_mnrch.sv - SPI monarch, 16-bit full-duplex mode-3 transactions for the iNEMO
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : spi_mnrch_if.master (wrt, cmd, done, resp, SS_n, SCLK, MOSI, MISO
//            and, with SPI_MNRCH_XACT_CNT_EN, xact_cnt and busy)
// Parameters:
//   DIV_W  : SCLK divider width, SCLK period = 2^DIV_W clk
//   DATA_W : bits per transaction
// Optional feature macro: SPI_MNRCH_XACT_CNT_EN (adds xact_cnt and busy)
//
// Timeline for DIV_W=5 (edge E0 samples wrt):
//   E0   SS_n falls, div=23, SCLK high for the 9-clk front porch
//   E9   first SCLK fall (no shift), bit periods begin
//   each period: MISO captured where div==15 (SCLK rises there),
//                shift where div==31 (SCLK falls there)
//   after the 16th capture SCLK is held high for a 16-clk back porch,
//   E521 final shift, SS_n high, done high

module spi_mnrch
    import spi_mnrch_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_mnrch_if.master    bus
);

    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [DIV_W-1:0] L_FRONT_LD = DIV_W'(front_ld(DIV_W));
    localparam logic [DIV_W-1:0] L_SMPL_PT  = DIV_W'(smpl_pt(DIV_W));
    localparam logic [DIV_W-1:0] L_SHFT_PT  = DIV_W'(shft_pt(DIV_W));
    localparam logic [BIT_W-1:0] L_LAST_BIT = BIT_W'(DATA_W - 1);

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [DATA_W-1:0]   r_shft;
    logic                r_miso_smpl;
    logic                r_ss_n;
    logic                r_sclk;
    logic                r_done;
`ifdef SPI_MNRCH_XACT_CNT_EN
    logic [15:0]         r_xact_cnt;
`endif

    logic [DIV_W-1:0]    w_div_inc;
    logic                w_at_smpl;
    logic                w_at_shft;

    assign w_div_inc = r_div + DIV_W'(1);
    assign w_at_smpl = (r_div == L_SMPL_PT);
    assign w_at_shft = (r_div == L_SHFT_PT);

    // SCLK is registered from the next divider value, so it equals the divider
    // MSB while active without a combinational path from the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_shft      <= '0;
            r_miso_smpl <= 1'b0;
            r_ss_n      <= 1'b1;
            r_sclk      <= 1'b1;
            r_done      <= 1'b0;
`ifdef SPI_MNRCH_XACT_CNT_EN
            r_xact_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.wrt) begin
                        r_shft    <= bus.cmd;
                        r_div     <= L_FRONT_LD;
                        r_bit_cnt <= '0;
                        r_done    <= 1'b0;
                        r_ss_n    <= 1'b0;
                        r_sclk    <= L_FRONT_LD[DIV_W-1];
                        r_state   <= FRONT;
                    end
                end

                // Front porch: the fall at the wrap only starts the first bit
                // period; MOSI already carries cmd[MSB] from the load.
                FRONT: begin
                    r_div  <= w_div_inc;
                    r_sclk <= w_div_inc[DIV_W-1];
                    if (w_at_shft) begin
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    r_div  <= w_div_inc;
                    r_sclk <= w_div_inc[DIV_W-1];
                    if (w_at_smpl) begin
                        r_miso_smpl <= bus.MISO;
                        // Last capture taken: the matching shift happens in BACK
                        // so SCLK is never driven low after the final rise.
                        if (r_bit_cnt == L_LAST_BIT) begin
                            r_state <= BACK;
                        end
                    end
                    if (w_at_shft) begin
                        r_shft    <= {r_shft[DATA_W-2:0], r_miso_smpl};
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                end

                BACK: begin
                    r_div  <= w_div_inc;
                    r_sclk <= 1'b1;
                    if (w_at_shft) begin
                        r_shft  <= {r_shft[DATA_W-2:0], r_miso_smpl};
                        r_ss_n  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
`ifdef SPI_MNRCH_XACT_CNT_EN
                        r_xact_cnt <= r_xact_cnt + 16'd1;
`endif
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_ss_n  <= 1'b1;
                    r_sclk  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.done = r_done;
    assign bus.resp = r_shft;
    assign bus.SS_n = r_ss_n;
    assign bus.SCLK = r_sclk;
    assign bus.MOSI = r_shft[DATA_W-1];

`ifdef SPI_MNRCH_XACT_CNT_EN
    assign bus.xact_cnt = r_xact_cnt;
    assign bus.busy     = ~r_ss_n;
`endif

endmodule
